// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Control sequencer for a pipelined DSP multiply-accumulate slice
//   (A/B input registers -> M multiplier register -> P accumulator).
//   A run of `len` sample pairs is requested with a one-cycle `start`;
//   sample pairs are accepted with a valid/ready handshake, and the
//   register-stage clock enables plus OPMODE are generated so that P ends
//   up holding the sum of all products of the run when `done` pulses.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle run request (ignored while busy or when len==0)
//   len       in   number of sample pairs, captured with start
//   in_valid  in   upstream A/B pair present
//   in_ready  out  pair will be accepted this cycle (FEED only)
//   cea/ceb   out  A/B register enables (= accept, combinational)
//   cem       out  M register enable (accept delayed 1 cycle)
//   cep       out  P register enable (accept delayed 2 cycles)
//   opmode    out  OPM_FIRST for the first product, OPM_ACC afterwards, 0 idle
//   busy      out  high outside IDLE
//   done      out  one-cycle pulse, P holds the final sum
module dsp_mac_sequencer #(
  parameter int          LEN_W     = 8,
  parameter logic [7:0]  OPM_FIRST = 8'h01,
  parameter logic [7:0]  OPM_ACC   = 8'h09
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cea,
  output logic             ceb,
  output logic             cem,
  output logic             cep,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             first_q, first_d;
  logic [1:0]       v_q, v_d;   // beat valid, aligned with M (bit0) and P (bit1)
  logic [1:0]       f_q, f_d;   // first-beat flag travelling with v
  logic             accept;

  assign in_ready = (state_q == S_FEED);
  assign accept   = in_valid & in_ready;
  assign cea      = accept;
  assign ceb      = accept;
  assign cem      = v_q[0];
  assign cep      = v_q[1];
  assign opmode   = cep ? (f_q[1] ? OPM_FIRST : OPM_ACC) : '0;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    first_d = first_q;
    v_d     = {v_q[0], accept};
    f_d     = {f_q[0], accept & first_q};
    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          state_d = S_FEED;
          count_d = len;
          first_d = 1'b1;
        end
      end
      S_FEED: begin
        if (accept) begin
          count_d = count_q - LEN_W'(1);
          first_d = 1'b0;
          if (count_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No accepts happen in DRAIN, so v_q[0]==0 means the pipe is empty
        // after this edge; the last cep is the one visible this cycle.
        if (!v_q[0]) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      first_q <= 1'b0;
      v_q     <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      first_q <= first_d;
      v_q     <= v_d;
      f_q     <= f_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer: event-scheduled reference model
// (beats scheduled forward in time by their latency), a small DSP slice
// model driven by the DUT enables, table-driven runs, hand sequences and a
// randomized soak.
module tb_dsp_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] len;
  logic       in_ready, cea, ceb, cem, cep, busy, done;
  logic [7:0] opmode;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(8), .OPM_FIRST(8'h01), .OPM_ACC(8'h09)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .cea(cea), .ceb(ceb), .cem(cem), .cep(cep),
    .opmode(opmode), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  localparam int NCYC = 8192;
  int         cyc = 0;
  bit         sc_cem [NCYC];
  bit         sc_cep [NCYC];
  logic [7:0] sc_op  [NCYC];
  bit         run_on = 0;
  int         remain = 0;
  int         beat = 0;
  int         done_at = -1;
  logic [31:0] exp_sum = 0;

  // DSP slice model fed by the DUT's enables
  logic [7:0]  a_s, b_s, dA = 0, dB = 0;
  logic [15:0] dM = 0;
  logic [31:0] dP = 0;

  int cep_seen, done_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input bit st, input int ln, input bit iv, input bit r);
    bit         e_ir, acc, e_cep, e_done;
    logic [7:0] e_op;
    logic [31:0] nP;
    logic [15:0] nM;
    start = st; len = ln[7:0]; in_valid = iv; rst = r;
    a_s = 8'($urandom); b_s = 8'($urandom);
    #3;
    e_ir   = run_on && (remain > 0);
    acc    = iv && e_ir;
    e_cep  = sc_cep[cyc];
    e_op   = e_cep ? sc_op[cyc] : 8'h00;
    e_done = run_on && (cyc == done_at);
    chk("in_ready", int'(in_ready), int'(e_ir));
    chk("cea", int'(cea), int'(acc));
    chk("ceb", int'(ceb), int'(acc));
    chk("cem", int'(cem), int'(sc_cem[cyc]));
    chk("cep", int'(cep), int'(e_cep));
    chk("opmode", int'(opmode), int'(e_op));
    chk("busy", int'(busy), int'(run_on));
    chk("done", int'(done), int'(e_done));
    if (e_done) chk("p_sum", int'(dP), int'(exp_sum));
    if (cep === 1'b1) cep_seen++;
    if (done === 1'b1) done_seen++;
    // DSP slice update, using pre-edge register values
    nP = cep ? ((opmode[3] ? dP : 32'd0) + (opmode[0] ? 32'(dM) : 32'd0)) : dP;
    nM = cem ? 16'(dA) * 16'(dB) : dM;
    if (cea) dA = a_s;
    if (ceb) dB = b_s;
    dM = nM; dP = nP;
    // reference model edge
    if (acc) begin
      sc_cem[cyc+1] = 1'b1;
      sc_cep[cyc+2] = 1'b1;
      sc_op[cyc+2]  = (beat == 0) ? 8'h01 : 8'h09;
      exp_sum += 32'(a_s) * 32'(b_s);
      beat++;
      remain--;
      if (remain == 0) done_at = cyc + 3;
    end
    if (r) begin
      for (int k = 1; k <= 3; k++) begin
        sc_cem[cyc+k] = 1'b0; sc_cep[cyc+k] = 1'b0;
      end
      run_on = 0; remain = 0; done_at = -1;
    end else if (run_on && cyc == done_at) begin
      run_on = 0;
    end else if (!run_on && st && (ln[7:0] != 8'd0)) begin
      run_on = 1; remain = int'(ln[7:0]); beat = 0; exp_sum = 0;
    end
    @(posedge clk);
    cyc++;
    if (cyc >= NCYC - 4) begin
      $display("FAIL cycle_budget cyc=%0d actual=%0d expected=<%0d", cyc, cyc, NCYC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
  endtask

  typedef struct {
    int          len;
    logic [31:0] mask;   // in_valid for the first 32 cycles after start, then 1
    int          exp_cep;
    int          exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v);
    cep_seen = 0; done_seen = 0;
    tick(1, v.len, 0, 0);
    for (int i = 0; i < v.len + 70; i++)
      tick(0, 0, (i < 32) ? v.mask[i] : 1'b1, 0);
    chk("cep_count", cep_seen, v.exp_cep);
    chk("done_count", done_seen, v.exp_done);
  endtask

  vec_t vecs [7];

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      sc_cem[i] = 0; sc_cep[i] = 0; sc_op[i] = 8'h00;
    end
    vecs[0] = '{4,   32'hFFFF_FFFF, 4,   1};
    vecs[1] = '{3,   32'hFFFF_FFF5, 3,   1};  // 1,0,1,0,1,...
    vecs[2] = '{1,   32'hFFFF_FFFF, 1,   1};
    vecs[3] = '{0,   32'hFFFF_FFFF, 0,   0};
    vecs[4] = '{5,   32'hFFFF_FF00, 5,   1};
    vecs[5] = '{7,   32'hAAAA_AAAA, 7,   1};
    vecs[6] = '{2,   32'h0000_0001, 2,   1};

    start = 0; len = 0; in_valid = 0; rst = 1;
    repeat (3) @(posedge clk);
    #1;
    // reset held: everything quiet
    tick(0, 0, 1, 1);
    tick(1, 4, 1, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start while busy and in the DONE cycle is ignored
    cep_seen = 0; done_seen = 0;
    tick(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 3, 1, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0);
    chk("busy_start_cep", cep_seen, 1);
    chk("busy_start_done", done_seen, 1);

    // reset after 2 of 5 accepts aborts the run
    cep_seen = 0; done_seen = 0;
    tick(1, 5, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 0);
    chk("abort_done", done_seen, 0);
    run_vec('{2, 32'hFFFF_FFFF, 2, 1});

    // maximum length, no wrap
    run_vec('{255, 32'hFFFF_FFFF, 255, 1});

    // randomized soak
    cep_seen = 0; done_seen = 0;
    for (int i = 0; i < 1500; i++)
      tick(($urandom_range(0, 7) == 0), int'($urandom_range(0, 12)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    for (int i = 0; i < 40; i++) tick(0, 0, 1, 0);
    chk("idle_at_end", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
